// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, dataBits LSB-first, optional parity, stopTicks of stop level.
// Define UART_TX_PARITY_EN to compile in the PARITY state and the parityOdd sense input.
module uart_tx_param #(
  parameter int dataBits   = 8,
  parameter int overSample = 16,
  parameter int stopTicks  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [dataBits-1:0] dataIn,
  input  logic                fifoNE,
  input  logic                ctsN,
  input  logic                parityOdd,
  output logic                fifoRd,
  output logic                tx,
  output logic                txBusy,
  output logic                txReady
);

  localparam int TMAX = (overSample > stopTicks) ? overSample : stopTicks;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(dataBits);

  localparam logic [TW-1:0] OS_LAST  = TW'(overSample - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(stopTicks - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(dataBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tickCnt_q, tickCnt_d;
  logic [BW-1:0]       bitCnt_q, bitCnt_d;
  logic [dataBits-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                bitDone;

`ifdef UART_TX_PARITY_EN
  logic parBit_q, parBit_d;

  // Parity is fixed at pop time, so the shift register is free to consume the word.
  function automatic logic frame_parity(input logic [dataBits-1:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction
`else
  logic unused_parityOdd;
  assign unused_parityOdd = parityOdd;
`endif

  assign bitDone = tick && (tickCnt_q == OS_LAST);

  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    fifoRd    = 1'b0;
    txReady   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parBit_d  = parBit_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fifoNE && !ctsN) begin
          fifoRd    = 1'b1;
          shift_d   = dataIn;
          tickCnt_d = '0;
          state_d   = S_START;
`ifdef UART_TX_PARITY_EN
          parBit_d  = frame_parity(dataIn, parityOdd);
`endif
        end
      end

      S_START: begin
        if (bitDone) begin
          tickCnt_d = '0;
          bitCnt_d  = '0;
          state_d   = S_DATA;
        end else if (tick) begin
          tickCnt_d = tickCnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bitDone) begin
          tickCnt_d = '0;
          shift_d   = shift_q >> 1;
          bitCnt_d  = bitCnt_q + 1'b1;
          if (bitCnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else if (tick) begin
          tickCnt_d = tickCnt_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bitDone) begin
          tickCnt_d = '0;
          state_d   = S_STOP;
        end else if (tick) begin
          tickCnt_d = tickCnt_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (tickCnt_q == ST_LAST) begin
            txReady   = 1'b1;
            tickCnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the next state so tx changes on the same edge as the state register.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parBit_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parBit_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parBit_q  <= parBit_d;
`endif
    end
  end

  assign tx     = tx_q;
  assign txBusy = busy_q;

endmodule
